dot_field_renderer: RTL and testbench
=====================================

// Module: dot_field_renderer
// PURPOSE
// - Downstream consumer of the 16x16 dot sprite ROM. Tiles the dot bitmap over the
//   640x480 field, one dot per 16x16 tile, and drives the per-pixel is_dot to the colour mapper.
// - Keeps a per-tile "eaten" map. Tiles are eaten once per frame at the player centre.
// - Reports the remaining dot count and an all-eaten flag to game control.
// PARAMETERS
// - TILE_LOG2  4     log2 of tile edge in pixels; must match the 16x16 sprite
// - COLS       40    tiles per row (640/16)
// - ROWS       30    tiles per column (480/16)
// - IDX_W      11    tile index width; must satisfy 2**IDX_W >= COLS*ROWS
// PORTS
// - Clk          in   1     pixel-domain clock
// - Reset        in   1     synchronous, active-high
// - DrawX        in   10    current pixel column
// - DrawY        in   10    current pixel row
// - pix_valid    in   1     1 = active video (not blanking)
// - rom_addr     out  6     dot ROM row address = {2'b00, DrawY[3:0]}; combinational
// - rom_data     in   16    dot ROM row; combinational ROM; MSB = leftmost pixel
// - frame_start  in   1     one-cycle pulse at start of vertical blank
// - restart      in   1     one-cycle pulse; re-arms every dot
// - player_x     in   10    player sprite top-left column
// - player_y     in   10    player sprite top-left row
// - is_dot       out  1     pixel belongs to an uneaten dot; 1-cycle latency
// - eat_pulse    out  1     one-cycle pulse when a dot is eaten
// - dots_left    out  IDX_W number of uneaten dots
// - all_eaten    out  1     high while in DONE
// BEHAVIOUR
// - Reset: all outputs 0 except rom_addr, which stays combinational. FSM enters INIT with
//   sweep_idx=0. The same applies to a Reset mid-operation: any in-flight eat is abandoned.
// - FSM states: INIT, RUN, EAT_CHK, DONE.
// - INIT
//   - Each cycle: write 0 to map[sweep_idx], then increment sweep_idx and dots_left.
//   - After index COLS*ROWS-1, go to RUN with dots_left=1200.
//   - is_dot is forced to 0 in this state.
//   - frame_start is ignored.
// - RUN, on frame_start
//   - Compute cx=player_x+8 and cy=player_y+8, 11-bit, no wrap.
//   - Compute tx=cx>>4 and ty=cy>>4.
//   - If tx<COLS && ty<ROWS: issue a read of map[ty*COLS+tx] and go to EAT_CHK.
//   - Otherwise stay in RUN and perform no eat.
// - EAT_CHK, 1 cycle
//   - If the read bit is 0: write 1, decrement dots_left, set eat_pulse=1.
//   - If dots_left becomes 0 the next state is DONE; otherwise it is RUN.
//   - If the read bit is 1: return to RUN with no change.
// - DONE: is_dot stays active for any remaining (none) dots; all_eaten=1 until restart.
// - restart in any state: go to INIT with sweep_idx=0 and dots_left=0.
//   - restart beats a coincident frame_start.
//   - restart beats an in-progress EAT_CHK, which then performs no write and no eat_pulse.
// - Render path:
//   - Cycle 0: read port R reads map[(DrawY>>4)*COLS+(DrawX>>4)]. Register rom_data,
//     DrawX[3:0] and pix_valid.
//   - Cycle 1: is_dot = valid_q & ~map_q & rom_data_q[15-x_q].
//   - Pixels with DrawX>=640 or DrawY>=480 give is_dot=0.
// - Map read-during-write returns old data.
//   - A pixel on the tile being eaten may show the dot for one extra cycle. This is acceptable.
// - Index multiply ty*COLS uses the constant COLS; result is truncated to IDX_W bits.
// STRUCTURE
// - Shared package dot_pkg holds:
//   - dot_state_t enum {INIT, RUN, EAT_CHK, DONE}
//   - constants TILE_LOG2, COLS, ROWS, NUM_TILES=COLS*ROWS, HALF_SPRITE=8
// - One sub-module, dot_eaten_map: NUM_TILES x 1-bit storage.
//   - Two synchronous read ports: render and eat.
//   - One synchronous write port.
//   - Read latency 1 cycle; read-during-write returns old data.
// - The top level contains the FSM, the sweep counter, dots_left and the render pipeline.
// TESTING
// - Reset 1 cycle, then run 1200 cycles -> state RUN, dots_left=1200, all_eaten=0;
//   is_dot=0 throughout INIT.
// - RUN, DrawX/DrawY stepped over row 7, cols 0..15 -> is_dot one cycle later is 1 only
//   for x=6..9.
// - RUN, row 6 of tile (3,2) (DrawY=38, DrawX=48..63) -> is_dot=1 only at DrawX=55,56.
// - player_x=0, player_y=0, then frame_start -> two cycles later eat_pulse=1 and
//   dots_left=1199.
//   - Afterwards DrawX=7/DrawY=7 gives is_dot=0.
//   - Repeating frame_start gives no eat_pulse and dots_left stays 1199.
// - player_x=700, then frame_start -> no eat_pulse, dots_left unchanged, state stays RUN.
// - restart coincident with frame_start on an uneaten tile -> INIT, no eat_pulse;
//   1200 cycles later dots_left=1200.

Source files
------------

// File: rtl/dot_pkg.sv
// dot_pkg: shared constants, FSM state type and tile-index helper for the dot field.
package dot_pkg;
  localparam int TILE_LOG2   = 4;
  localparam int COLS        = 40;
  localparam int ROWS        = 30;
  localparam int NUM_TILES   = COLS * ROWS;
  localparam int HALF_SPRITE = 8;
  localparam int IDX_W       = 11;
  typedef enum logic [1:0] {INIT, RUN, EAT_CHK, DONE} dot_state_t;
  function automatic logic [IDX_W-1:0] tile_idx(input logic [10:0] ty, input logic [10:0] tx);
    return IDX_W'(ty * 11'(COLS) + tx);
  endfunction
endpackage

// File: rtl/dot_eaten_map.sv
// dot_eaten_map: per-tile eaten bits, two sync read ports, one sync write port, old data on collision.
module dot_eaten_map
  import dot_pkg::*;
(
  input  logic             Clk,
  input  logic [IDX_W-1:0] i_ren_addr,
  output logic             o_ren_q,
  input  logic [IDX_W-1:0] i_eat_addr,
  output logic             o_eat_q,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic             i_wdata
);
  logic r_mem [NUM_TILES];
  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_ren_q <= (i_ren_addr < IDX_W'(NUM_TILES)) ? r_mem[i_ren_addr] : 1'b1;
    o_eat_q <= (i_eat_addr < IDX_W'(NUM_TILES)) ? r_mem[i_eat_addr] : 1'b1;
  end
endmodule

// File: rtl/dot_field_renderer.sv
// dot_field_renderer: tiles the dot sprite over the field, tracks eaten tiles and the remaining dot count.
module dot_field_renderer
  import dot_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             pix_valid,
  output logic [5:0]       rom_addr,
  input  logic [15:0]      rom_data,
  input  logic             frame_start,
  input  logic             restart,
  input  logic [9:0]       player_x,
  input  logic [9:0]       player_y,
  output logic             is_dot,
  output logic             eat_pulse,
  output logic [IDX_W-1:0] dots_left,
  output logic             all_eaten
);
  dot_state_t       r_state, w_next;
  logic [IDX_W-1:0] r_sweep, r_eat_idx, r_dots;
  logic [IDX_W-1:0] w_ren_addr, w_eat_addr, w_waddr;
  logic [10:0]      w_cx, w_cy;
  logic [15:0]      r_rom;
  logic [3:0]       r_x;
  logic             r_valid, r_eat_pulse, w_ren_q, w_eat_q, w_tile_ok, w_eat, w_we;

  assign rom_addr   = {2'b00, DrawY[3:0]};
  assign w_cx       = {1'b0, player_x} + 11'(HALF_SPRITE);
  assign w_cy       = {1'b0, player_y} + 11'(HALF_SPRITE);
  assign w_tile_ok  = (w_cx >> TILE_LOG2) < 11'(COLS) && (w_cy >> TILE_LOG2) < 11'(ROWS);
  assign w_eat_addr = tile_idx(w_cy >> TILE_LOG2, w_cx >> TILE_LOG2);
  assign w_ren_addr = tile_idx({1'b0, DrawY} >> TILE_LOG2, {1'b0, DrawX} >> TILE_LOG2);
  // Reset and restart both abandon an eat that is still being checked
  assign w_eat      = r_state == EAT_CHK && !w_eat_q && !restart && !Reset;
  assign w_we       = r_state == INIT || w_eat;
  assign w_waddr    = r_state == INIT ? r_sweep : r_eat_idx;

  dot_eaten_map u_map (
    .Clk       (Clk),
    .i_ren_addr(w_ren_addr),
    .o_ren_q   (w_ren_q),
    .i_eat_addr(w_eat_addr),
    .o_eat_q   (w_eat_q),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (r_state != INIT)
  );

  always_comb begin
    w_next = r_state;
    if (restart) w_next = INIT;
    else if (r_state == INIT) w_next = r_sweep == IDX_W'(NUM_TILES - 1) ? RUN : INIT;
    else if (r_state == RUN) w_next = frame_start && w_tile_ok ? EAT_CHK : RUN;
    else if (r_state == EAT_CHK) w_next = w_eat && r_dots == IDX_W'(1) ? DONE : RUN;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= INIT;
      r_sweep     <= '0;
      r_dots      <= '0;
      r_eat_idx   <= '0;
      r_eat_pulse <= 1'b0;
      r_valid     <= 1'b0;
      r_x         <= '0;
      r_rom       <= '0;
    end else begin
      r_state     <= w_next;
      r_sweep     <= (restart || r_state != INIT) ? '0 : r_sweep + 1'b1;
      r_dots      <= restart ? '0 : r_state == INIT ? r_dots + 1'b1 : w_eat ? r_dots - 1'b1 : r_dots;
      r_eat_idx   <= r_state == RUN ? w_eat_addr : r_eat_idx;
      r_eat_pulse <= w_eat;
      r_valid     <= pix_valid && DrawX < 10'(COLS << TILE_LOG2) && DrawY < 10'(ROWS << TILE_LOG2);
      r_x         <= DrawX[3:0];
      r_rom       <= rom_data;
    end
  end

  assign is_dot    = r_valid && !w_ren_q && r_rom[4'd15 - r_x] && r_state != INIT;
  assign eat_pulse = r_eat_pulse;
  assign dots_left = r_dots;
  assign all_eaten = r_state == DONE;
endmodule

// File: tb/tb_dot_field_renderer.sv
// tb_dot_field_renderer: randomized render/eat checks against a tile-map model of the dot field.
module tb_dot_field_renderer;
  logic        Clk = 1'b0, Reset = 1'b0, pix_valid = 1'b0, frame_start = 1'b0, restart = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, player_x = '0, player_y = '0;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        is_dot, eat_pulse, all_eaten;
  logic [10:0] dots_left;
  int          vecs = 0, errs = 0, m_dots = 0;
  bit          eaten [1200];

  dot_field_renderer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .frame_start(frame_start), .restart(restart),
    .player_x(player_x), .player_y(player_y), .is_dot(is_dot), .eat_pulse(eat_pulse),
    .dots_left(dots_left), .all_eaten(all_eaten)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] rom_row(input logic [3:0] r);
    return (r == 4'd6 || r == 4'd9) ? 16'h0180 : (r == 4'd7 || r == 4'd8) ? 16'h03C0 : 16'h0000;
  endfunction
  assign rom_data = rom_row(rom_addr[3:0]);

  // the dot is a small disc: 2 wide on rows 6 and 9, 4 wide on rows 7 and 8
  function automatic bit in_shape(input int c, input int r);
    if (r == 6 || r == 9) return c == 7 || c == 8;
    if (r == 7 || r == 8) return c >= 6 && c <= 9;
    return 1'b0;
  endfunction

  function automatic bit exp_dot(input int x, input int y, input bit v);
    if (!v || x >= 640 || y >= 480) return 1'b0;
    if (eaten[(y / 16) * 40 + x / 16]) return 1'b0;
    return in_shape(x % 16, y % 16);
  endfunction

  function automatic int eat_tile(input int px, input int py);
    int tx = (px + 8) / 16, ty = (py + 8) / 16;
    return (tx < 40 && ty < 30) ? ty * 40 + tx : -1;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit v);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_valid = v;
    step();
  endtask

  task automatic fire(input int px, input int py);
    pix_valid = 1'b0;
    player_x = 10'(px);
    player_y = 10'(py);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic clear_model();
    foreach (eaten[i]) eaten[i] = 1'b0;
    m_dots = 1200;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    pix(7, 7, 1'b1);
    Reset = 1'b0;
    vecs++;
    if (dots_left !== 11'd0 || all_eaten !== 1'b0 || eat_pulse !== 1'b0 || is_dot !== 1'b0) begin
      errs++;
      $display("FAIL reset: dots=%0d all=%b eat=%b dot=%b, want 0 0 0 0", dots_left, all_eaten, eat_pulse, is_dot);
    end
    for (int i = 1; i <= 1200; i++) begin
      pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
      if (i < 1200) begin
        vecs++;
        if (is_dot !== 1'b0) begin
          errs++;
          $display("FAIL init_is_dot cycle %0d: got %b want 0", i, is_dot);
        end
      end
    end
    clear_model();
    vecs++;
    if (dots_left !== 11'd1200 || all_eaten !== 1'b0) begin
      errs++;
      $display("FAIL init_done: dots=%0d all=%b, want 1200 0", dots_left, all_eaten);
    end
  endtask

  task automatic test_render_rows();
    for (int x = 0; x < 16; x++) begin
      pix(x, 7, 1'b1);
      vecs++;
      if (is_dot !== exp_dot(x, 7, 1'b1)) begin
        errs++;
        $display("FAIL row7 x=%0d: got %b want %b", x, is_dot, exp_dot(x, 7, 1'b1));
      end
    end
    for (int x = 48; x < 64; x++) begin
      pix(x, 38, 1'b1);
      vecs++;
      if (is_dot !== exp_dot(x, 38, 1'b1)) begin
        errs++;
        $display("FAIL tile32 x=%0d: got %b want %b", x, is_dot, exp_dot(x, 38, 1'b1));
      end
    end
  endtask

  task automatic test_random_render(input int n);
    for (int i = 0; i < n; i++) begin
      int x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
      int y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 479));
      bit v = $urandom_range(0, 4) != 0;
      pix(x, y, v);
      vecs++;
      if (is_dot !== exp_dot(x, y, v)) begin
        errs++;
        $display("FAIL render (%0d,%0d,v=%b): got %b want %b", x, y, v, is_dot, exp_dot(x, y, v));
      end
    end
  endtask

  task automatic test_eats(input int n);
    int px, py, t;
    bit exp_pulse;
    for (int i = 0; i < n + 6; i++) begin
      case (i)
        0: begin px = 0;   py = 0;   end
        1: begin px = 0;   py = 0;   end
        2: begin px = 700; py = 100; end
        3: begin px = 632; py = 0;   end
        4: begin px = 631; py = 0;   end
        5: begin px = 0;   py = 471; end
        default: begin px = int'($urandom_range(0, 660)); py = int'($urandom_range(0, 500)); end
      endcase
      if (i == 6) begin px = 0; py = 472; end
      t = eat_tile(px, py);
      exp_pulse = t >= 0 && !eaten[t];
      if (exp_pulse) begin
        eaten[t] = 1'b1;
        m_dots--;
      end
      fire(px, py);
      vecs++;
      if (eat_pulse !== exp_pulse || dots_left !== 11'(m_dots)) begin
        errs++;
        $display("FAIL eat (%0d,%0d): pulse=%b dots=%0d, want %b %0d", px, py, eat_pulse, dots_left, exp_pulse, m_dots);
      end
      if (t >= 0) begin
        pix((t % 40) * 16 + 7, (t / 40) * 16 + 7, 1'b1);
        vecs++;
        if (is_dot !== 1'b0) begin
          errs++;
          $display("FAIL eaten_tile %0d: got %b want 0", t, is_dot);
        end
      end
    end
  endtask

  task automatic test_restart_in_eat_chk();
    int t = eat_tile(160, 160);
    player_x = 10'd160;
    player_y = 10'd160;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    vecs++;
    if (eat_pulse !== 1'b0 || dots_left !== 11'd0) begin
      errs++;
      $display("FAIL restart_eat_chk tile %0d: pulse=%b dots=%0d, want 0 0", t, eat_pulse, dots_left);
    end
    repeat (1200) step();
    clear_model();
    vecs++;
    if (dots_left !== 11'd1200) begin
      errs++;
      $display("FAIL restart_eat_chk_reinit: dots=%0d want 1200", dots_left);
    end
  endtask

  task automatic test_restart_coincident();
    eaten[0] = 1'b1;
    fire(0, 0);
    player_x = 10'd16;
    player_y = 10'd0;
    frame_start = 1'b1;
    restart = 1'b1;
    step();
    frame_start = 1'b0;
    restart = 1'b0;
    vecs++;
    if (eat_pulse !== 1'b0 || dots_left !== 11'd0) begin
      errs++;
      $display("FAIL restart_coincident: pulse=%b dots=%0d, want 0 0", eat_pulse, dots_left);
    end
    step();
    vecs++;
    if (eat_pulse !== 1'b0) begin
      errs++;
      $display("FAIL restart_coincident_late: pulse=%b want 0", eat_pulse);
    end
    repeat (1198) step();
    clear_model();
    pix(7, 7, 1'b1);
    vecs++;
    if (dots_left !== 11'd1200 || is_dot !== 1'b1) begin
      errs++;
      $display("FAIL restart_reinit: dots=%0d dot=%b, want 1200 1", dots_left, is_dot);
    end
  endtask

  task automatic test_all_eaten();
    for (int t = 0; t < 1200; t++) begin
      fire((t % 40) * 16, (t / 40) * 16);
      eaten[t] = 1'b1;
      m_dots--;
      vecs++;
      if (eat_pulse !== 1'b1 || dots_left !== 11'(m_dots) || all_eaten !== (m_dots == 0)) begin
        errs++;
        $display("FAIL sweep_eat tile %0d: pulse=%b dots=%0d all=%b, want 1 %0d %b", t, eat_pulse, dots_left, all_eaten, m_dots, m_dots == 0);
      end
    end
    fire(320, 240);
    pix(327, 247, 1'b1);
    vecs++;
    if (eat_pulse !== 1'b0 || all_eaten !== 1'b1 || dots_left !== 11'd0 || is_dot !== 1'b0) begin
      errs++;
      $display("FAIL done_hold: pulse=%b all=%b dots=%0d dot=%b, want 0 1 0 0", eat_pulse, all_eaten, dots_left, is_dot);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    vecs++;
    if (all_eaten !== 1'b0 || dots_left !== 11'd0) begin
      errs++;
      $display("FAIL done_restart: all=%b dots=%0d, want 0 0", all_eaten, dots_left);
    end
  endtask

  initial begin
    test_reset();
    test_render_rows();
    test_random_render(150);
    test_eats(30);
    test_random_render(300);
    test_restart_in_eat_chk();
    test_restart_coincident();
    test_all_eaten();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
